apb_wait_slave: RTL

- APB completer that sits directly downstream of the APB master on one PSEL line, in the same position as the existing slave1/slave2.
- Holds a 256 x 8 register file and inserts a fixed number of wait states on every access.
- Flags PSLVERR for addresses above a programmable limit.
- Used to exercise the master's PREADY stall and error paths.

---
 rtl/apb_wait_slave.sv | 121 ++++++++++++
 1 files changed

// File: rtl/apb_wait_slave.sv
// APB completer with a 256 x 8 register file, a fixed number of wait states per access
// and PSLVERR for offsets above a programmable limit.
module apb_wait_slave #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [7:0]  ADDR_LIMIT  = 8'd191,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [8:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(WAIT_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             write_q, write_d;
  logic [7:0]       mem_q [256];

  logic             ready_d, err_d;
  logic [7:0]       rdata_d;
  logic             mem_we;
  logic             setup, access, addr_err;
  logic             unused_sel;

  assign setup      = PSEL && !PENABLE;
  assign access     = PSEL && PENABLE;
  assign addr_err   = addr_q > ADDR_LIMIT;
  // Bit 8 only selects this slave at the master; the offset is bits [7:0].
  assign unused_sel = PADDR[8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      PREADY  <= ready_d;
      PSLVERR <= err_d;
      PRDATA  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (setup) begin
          addr_d  = PADDR[7:0];
          wdata_d = PWDATA;
          write_d = PWRITE;
          cnt_d   = WaitLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!PSEL) begin
          state_d = StIdle;
        end else if (PENABLE) begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    mem_we  = 1'b0;
    unique case (state_q)
      StWait: begin
        if (access && cnt_q == '0) begin
          ready_d = 1'b1;
          err_d   = addr_err;
          if (!addr_err && !write_q) rdata_d = mem_q[addr_q];
        end
      end
      // The master completes on the edge that ends the PREADY cycle.
      StDone:  mem_we = write_q && !addr_err;
      default: ;
    endcase
  end

endmodule
